laser_cover_scorer: RTL and testbench
=====================================

Name: laser_cover_scorer

Overview:
- Downstream checker for the two-circle laser placement engine.
- Snoops the same 40-point X/Y stream the engine receives and latches the engine's C1/C2 result when the engine raises DONE.
- Computes the number of stored points inside the union of the two radius-4 circles and presents it as SCORE with a one-cycle SCORE_VALID strobe.
- Used for on-chip self-check and bench scoring.

Parameters:
- NPTS, 40, number of points per frame.
- R2, 16, squared circle radius; a point is covered when dx*dx + dy*dy <= R2.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- IN_VALID  in  1  X/Y carry a valid point this cycle.
- X  in  4  point x coordinate, 0..15.
- Y  in  4  point y coordinate, 0..15.
- DONE  in  1  engine DONE; the rising edge marks C1/C2 valid.
- C1X  in  4  circle 1 centre x.
- C1Y  in  4  circle 1 centre y.
- C2X  in  4  circle 2 centre x.
- C2Y  in  4  circle 2 centre y.
- SCORE  out  6  covered-point count, 0..NPTS.
- SCORE_VALID  out  1  one-cycle strobe; SCORE is valid while high.
- ERR  out  1  high with SCORE_VALID when DONE rose before NPTS points were captured.
- BUSY  out  1  high in SCORE state.

Behaviour:
- Reset (synchronous, RST high at a clock edge):
  - state=CAPTURE, point count=0, SCORE=0, SCORE_VALID=0, ERR=0, BUSY=0.
  - done_q=1, so a DONE that is already high after reset is not an edge.
  - Point storage is not cleared.
- Rising-edge detection: done_q holds the previous cycle's DONE. rise = DONE & ~done_q.
- States:
  - CAPTURE:
    - Each IN_VALID with count<NPTS writes X/Y to slot[count] and increments count.
    - IN_VALID at count==NPTS is ignored.
    - rise: latch C1X/C1Y/C2X/C2Y and idx=0, acc=0.
      - If count==NPTS, go to SCORE.
      - If count<NPTS, set err_r=1 and go to OUT with acc=0.
  - SCORE:
    - One point per cycle.
    - d1 = |px-C1X|^2 + |py-C1Y|^2 and d2 likewise for C2. Differences are 4-bit absolute, squares 8-bit, sums 9-bit unsigned, no truncation.
    - cov = (d1<=R2) | (d2<=R2). A point inside both circles counts once.
    - acc += cov; idx++.
    - After the idx==NPTS-1 evaluation, go to OUT.
    - IN_VALID and DONE are ignored in this state.
  - OUT:
    - One cycle: SCORE=acc, SCORE_VALID=1, ERR=err_r.
    - Next edge: go to CAPTURE with count=0 and err_r=0.
    - SCORE holds its value until the next OUT; SCORE_VALID and ERR return to 0.
- Latency: with rise sampled at edge E, SCORE_VALID is high during the cycle after edge E+NPTS+1 (NPTS scoring cycles plus one).
- Error path: SCORE_VALID is high the cycle after edge E+1, with SCORE=0 and ERR=1.
- BUSY=1 exactly during SCORE.
- A rise in any state other than CAPTURE is ignored. done_q still updates every cycle.
- IN_VALID in the same cycle as rise in CAPTURE:
  - The point is stored first (count increments).
  - The count==NPTS check uses the post-store count.
- RST mid-SCORE or mid-OUT: abort immediately. No SCORE_VALID is emitted and the next cycle is CAPTURE with count=0.
- Coordinates wrap-free: all arithmetic is unsigned on 0..15. The maximum d is 450, which fits 9 bits.

Test Plan:
- All 40 points at (5,5), C1=(5,5), C2=(0,0), DONE 0->1 -> SCORE=40, ERR=0, SCORE_VALID one cycle exactly NPTS+1 edges after the rise.
- Boundary radius, C1=(5,5), C2=(15,15):
  - 20 points at (9,5) (d1=16) and 20 points at (10,5) (d1=25, d2=125) -> SCORE=20.
  - Repeat with (8,8) (d1=18) replacing (9,5) -> SCORE=0.
- Overlap, C1=C2=(7,7): 40 points at (7,9) -> SCORE=40, not 80. With 10 of them moved to (0,0) -> SCORE=30.
- Early DONE: 25 points sent, DONE rises -> next cycle SCORE_VALID=1, SCORE=0, ERR=1. The following frame of 40 points scores normally with ERR=0.
- DONE held high from reset through 40 points (no rise) -> no SCORE_VALID. Drop DONE then raise it -> scoring starts.
- RST asserted for one cycle in the 20th SCORE cycle -> no SCORE_VALID, BUSY=0 next cycle. A new 40-point frame followed by a DONE rise produces the correct score.

Source files
------------

// File: rtl/laser_cover_scorer.sv
// Downstream checker for the two-circle laser placement engine: snoops the point
// stream, latches C1/C2 on the engine's DONE rising edge and counts covered points.
module laser_cover_scorer #(
    parameter int NPTS = 40,
    parameter int R2   = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic [5:0] SCORE,
    output logic       SCORE_VALID,
    output logic       ERR,
    output logic       BUSY
);

    localparam int              CNT_W  = $clog2(NPTS + 1);
    localparam logic [CNT_W-1:0] NPTS_C = CNT_W'(NPTS);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NPTS - 1);
    localparam logic [8:0]       R2_C   = 9'(R2);

    typedef enum logic [1:0] {
        S_CAPTURE,
        S_SCORE,
        S_OUT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] idx;
    logic [5:0]       acc;
    logic             err_r;
    logic             done_q;

    logic [3:0] px [NPTS];
    logic [3:0] py [NPTS];
    logic [3:0] c1x, c1y, c2x, c2y;

    logic             rise;
    logic             store;
    logic [CNT_W-1:0] cnt_post;
    logic [3:0]       px_cur, py_cur;
    logic [8:0]       d1, d2;
    logic             cov;

    // Squared Euclidean distance on 4-bit unsigned coordinates; max 450 fits 9 bits.
    function automatic logic [8:0] dist2(input logic [3:0] ax, input logic [3:0] ay,
                                         input logic [3:0] bx, input logic [3:0] by);
        logic [3:0] dx, dy;
        logic [7:0] sx, sy;
        dx = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy = (ay >= by) ? (ay - by) : (by - ay);
        sx = 8'(dx) * 8'(dx);
        sy = 8'(dy) * 8'(dy);
        return 9'(sx) + 9'(sy);
    endfunction

    assign rise     = DONE & ~done_q;
    assign store    = (state == S_CAPTURE) && IN_VALID && (count < NPTS_C);
    // The full-frame test on a DONE edge must see a point stored in the same cycle.
    assign cnt_post = store ? (count + 1'b1) : count;

    assign px_cur = px[idx];
    assign py_cur = py[idx];
    assign d1     = dist2(px_cur, py_cur, c1x, c1y);
    assign d2     = dist2(px_cur, py_cur, c2x, c2y);
    assign cov    = (d1 <= R2_C) | (d2 <= R2_C);

    assign BUSY = (state == S_SCORE);

    // Point storage and latched circle centres carry no reset.
    always_ff @(posedge CLK) begin
        if (store) begin
            px[count] <= X;
            py[count] <= Y;
        end
        if ((state == S_CAPTURE) && rise) begin
            c1x <= C1X;
            c1y <= C1Y;
            c2x <= C2X;
            c2y <= C2Y;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_CAPTURE;
            count       <= '0;
            idx         <= '0;
            acc         <= '0;
            err_r       <= 1'b0;
            done_q      <= 1'b1;
            SCORE       <= '0;
            SCORE_VALID <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            done_q      <= DONE;
            SCORE_VALID <= 1'b0;
            ERR         <= 1'b0;
            case (state)
                S_CAPTURE: begin
                    count <= cnt_post;
                    if (rise) begin
                        idx <= '0;
                        acc <= '0;
                        if (cnt_post == NPTS_C) begin
                            state <= S_SCORE;
                        end else begin
                            err_r <= 1'b1;
                            state <= S_OUT;
                        end
                    end
                end
                S_SCORE: begin
                    acc <= acc + {5'b0, cov};
                    idx <= idx + 1'b1;
                    if (idx == LAST_C) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    SCORE       <= acc;
                    SCORE_VALID <= 1'b1;
                    ERR         <= err_r;
                    err_r       <= 1'b0;
                    count       <= '0;
                    state       <= S_CAPTURE;
                end
                default: state <= S_CAPTURE;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_cover_scorer.sv
// Directed bench for laser_cover_scorer: expected score/err/cycle are queued on
// each DONE rise and checked when SCORE_VALID appears.
module tb_laser_cover_scorer;

    localparam int NPTS = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] x = '0, y = '0;
    logic       done = 1'b0;
    logic [3:0] c1x = '0, c1y = '0, c2x = '0, c2y = '0;
    logic [5:0] score;
    logic       score_valid, err, busy;

    typedef struct {
        logic [5:0] score;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [5:0] last_score = '0;

    laser_cover_scorer #(.NPTS(NPTS), .R2(16)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .X(x), .Y(y), .DONE(done),
        .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y),
        .SCORE(score), .SCORE_VALID(score_valid), .ERR(err), .BUSY(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (score_valid === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_valid: observed SCORE_VALID=1 at cycle %0d expected 0", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("score", int'(score), int'(e.score));
                check("err", int'(err), int'(e.err));
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pts(input int n, input logic [3:0] px, input logic [3:0] py);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            x = px;
            y = py;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic centres(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        c1x = a; c1y = b; c2x = c; c2y = d;
    endtask

    task automatic expect_out(input logic [5:0] s, input logic e);
        sb.push_back('{s, e, cyc + (e ? 2 : NPTS + 2)});
        last_score = s;
    endtask

    task automatic raise(input logic [5:0] s, input logic e);
        done = 1'b1;
        expect_out(s, e);
        tick();
        done = 1'b0;
        check("busy_after_rise", int'(busy), e ? 0 : 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
        check("drain_pending", sb.size(), 0);
        tick();
        check("score_hold", int'(score), int'(last_score));
        check("valid_low", int'(score_valid), 0);
        check("err_low", int'(err), 0);
        check("busy_idle", int'(busy), 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_score", int'(score), 0);
        check("rst_valid", int'(score_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);

        // All points on C1.
        centres(4'd5, 4'd5, 4'd0, 4'd0);
        pts(40, 4'd5, 4'd5);
        raise(6'd40, 1'b0);
        drain();

        // Radius boundary: d1=16 covered, d1=25 not.
        centres(4'd5, 4'd5, 4'd15, 4'd15);
        pts(20, 4'd9, 4'd5);
        pts(20, 4'd10, 4'd5);
        raise(6'd20, 1'b0);
        drain();

        pts(20, 4'd8, 4'd8);
        pts(20, 4'd10, 4'd5);
        raise(6'd0, 1'b0);
        drain();

        // Coincident circles count each point once.
        centres(4'd7, 4'd7, 4'd7, 4'd7);
        pts(40, 4'd7, 4'd9);
        raise(6'd40, 1'b0);
        drain();

        // Last point stored in the same cycle as the DONE edge.
        pts(10, 4'd0, 4'd0);
        pts(29, 4'd7, 4'd9);
        in_valid = 1'b1; x = 4'd7; y = 4'd9; done = 1'b1;
        expect_out(6'd30, 1'b0);
        tick();
        in_valid = 1'b0; done = 1'b0;
        check("busy_same_cycle", int'(busy), 1);
        drain();

        // Early DONE.
        centres(4'd5, 4'd6, 4'd15, 4'd15);
        pts(25, 4'd5, 4'd5);
        raise(6'd0, 1'b1);
        drain();
        pts(40, 4'd5, 4'd5);
        raise(6'd40, 1'b0);
        drain();

        // DONE high out of reset is not an edge.
        done = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        centres(4'd5, 4'd5, 4'd0, 4'd0);
        pts(40, 4'd5, 4'd5);
        for (int i = 0; i < 50; i++) tick();
        check("held_done_busy", int'(busy), 0);
        done = 1'b0;
        tick();
        raise(6'd40, 1'b0);
        drain();

        // Reset during scoring aborts without output.
        centres(4'd0, 4'd0, 4'd15, 4'd15);
        pts(40, 4'd0, 4'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check("busy_mid_score", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        for (int i = 0; i < 50; i++) tick();
        pts(15, 4'd0, 4'd0);
        pts(25, 4'd8, 4'd8);
        raise(6'd15, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
